cue_strike: RTL and testbench
=============================

# cue_strike

Shot controller between the cue geometry stage and the ball physics stage. It consumes the cue edge points, charges shot power while the shoot key is held, animates the cue pull-back and strike, and emits a one-clock hit pulse with a signed velocity vector for the white ball. It also gates cue rotation and cue visibility while a shot is in progress.

## Interface
- MAX_POWER, 15: power saturation value (4-bit)
- CHARGE_DIV, 4: frames per power increment
- PULL_STEP, 2: pixels of pull-back per power unit
- STRIKE_STEP, 6: pixels of pull-back removed per frame during strike
- VEL_DIV, 8: velocity divisor
- MIN_WAIT, 2: minimum frames in WAIT before release
- clk  input  1  system clock
- resetN  input  1  asynchronous active-low reset
- start_frame  input  1  one-clock frame tick; all state advances are qualified by it
- closeEdgeX, closeEdgeY  input  int  cue edge nearer the ball (screen px, signed)
- farEdgeX, farEdgeY  input  int  cue edge farther from the ball
- shoot_key  input  1  level, high while the shoot key is held
- balls_moving  input  1  high while any ball has non-zero velocity
- pull_back  output  int  cue retraction in px along the cue axis, for the cue drawer
- power  output  4  current shot power
- hit_pulse  output  1  one-clock strike event
- velocityX, velocityY  output  int  signed initial white-ball velocity, valid when hit_pulse is high and held until the next shot
- rotate_enable  output  1  high only in IDLE; gates the rotate inputs of the cue geometry stage
- cue_visible  output  1  low in WAIT

## Operation
- States: IDLE, CHARGE, STRIKE, WAIT. Transitions are evaluated only on cycles with start_frame=1, except hit_pulse deassertion.
- IDLE: if shoot_key=1 and balls_moving=0, go to CHARGE with power=0 and frame_cnt=0. A key press while balls_moving=1 is ignored.
- CHARGE, key still high: frame_cnt increments. When frame_cnt==CHARGE_DIV-1, set frame_cnt=0 and power=min(power+1, MAX_POWER).
- CHARGE, key low:
  - If power==0, return to IDLE with no hit.
  - Otherwise latch dx=closeEdgeX-farEdgeX and dy=closeEdgeY-farEdgeY, then go to STRIKE.
- Edge changes after the latch have no effect on the shot.
- pull_back = power*PULL_STEP in CHARGE. It is 0 in IDLE and WAIT.
- STRIKE: each frame, pull_back decreases by STRIKE_STEP.
  - When pull_back<=STRIKE_STEP, set pull_back=0, load velocityX=(dx*power)/VEL_DIV and velocityY=(dy*power)/VEL_DIV, assert hit_pulse on the next clock for exactly one clock, and go to WAIT.
  - Division is signed and truncates toward zero. Products are 32-bit signed.
- shoot_key is ignored in STRIKE.
- WAIT: frame_cnt counts frames. Exit to IDLE on the first start_frame with frame_cnt>=MIN_WAIT and balls_moving=0. On exit, clear power to 0.
- rotate_enable=(state==IDLE). cue_visible=(state!=WAIT).

## Timing
- Reset values: state IDLE, power 0, pull_back 0, hit_pulse 0, velocityX/Y 0, rotate_enable 1, cue_visible 1, frame_cnt 0.
- All outputs are registered. They update the clock after the qualifying start_frame.
- hit_pulse is high for one clk, never longer, regardless of how long start_frame stays high.
- Latency from key release to hit is ceil(pull_back/STRIKE_STEP) frames, plus one frame to sample the release.
- Reset mid-shot returns immediately to the reset values. No hit_pulse is emitted.
- Simultaneous release and power saturation within a frame: release takes priority, and power keeps its pre-increment value.

## Structure
- Shared package cue_pkg holds:
  - the state enum typedef (IDLE/CHARGE/STRIKE/WAIT)
  - the parameter defaults
  - the int coordinate convention, shared with the cue geometry stage
- No sub-module needed. A single FSM with datapath is 150–250 lines.
- The velocity multiply/divide may be a local function.

## Test plan
- Cue at 180°, ball at (320,240): close=(288,240), far=(192,240). Press key, hold 24 frames after entry, release -> power 6, pull_back 12, STRIKE 2 frames, hit_pulse 1 clk, velocity (72,0).
- Hold key 100 frames, cue at 90° (dx=0, dy=96) -> power saturates at 15, pull_back 30, velocity (0,180) after 5 strike frames.
- Press and release within 3 frames -> power 0, return to IDLE, no hit_pulse, rotate_enable stays high.
- Press key while balls_moving=1 -> remains IDLE. After the hit, balls_moving held high 10 frames -> cue_visible=0 until the first frame after it drops (and ≥MIN_WAIT). Then IDLE with power 0.
- Assert resetN low in mid-STRIKE -> all outputs return to reset values asynchronously, and no hit_pulse occurs.
- Change the edge inputs during STRIKE -> velocity reflects the edges latched at release only.

Source files
------------

// File: rtl/cue_pkg.sv
// cue_pkg: shared types and defaults for the cue pipeline stages.
// Screen coordinates are plain signed 32-bit ints throughout.
package cue_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHARGE,
    STRIKE,
    WAIT
  } state_t;

  typedef int coord_t;

  localparam int MAX_POWER_D   = 15;
  localparam int CHARGE_DIV_D  = 4;
  localparam int PULL_STEP_D   = 2;
  localparam int STRIKE_STEP_D = 6;
  localparam int VEL_DIV_D     = 8;
  localparam int MIN_WAIT_D    = 2;

endpackage

// File: rtl/cue_strike.sv
// cue_strike: shot FSM that charges power, animates the cue stroke
// and fires a one-clock hit with the white-ball velocity.
module cue_strike
  import cue_pkg::*;
#(
  parameter int MAX_POWER   = MAX_POWER_D,
  parameter int CHARGE_DIV  = CHARGE_DIV_D,
  parameter int PULL_STEP   = PULL_STEP_D,
  parameter int STRIKE_STEP = STRIKE_STEP_D,
  parameter int VEL_DIV     = VEL_DIV_D,
  parameter int MIN_WAIT    = MIN_WAIT_D
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start_frame,
  input  coord_t     closeEdgeX,
  input  coord_t     closeEdgeY,
  input  coord_t     farEdgeX,
  input  coord_t     farEdgeY,
  input  logic       shoot_key,
  input  logic       balls_moving,
  output coord_t     pull_back,
  output logic [3:0] power,
  output logic       hit_pulse,
  output coord_t     velocityX,
  output coord_t     velocityY,
  output logic       rotate_enable,
  output logic       cue_visible
);

  state_t     state, state_n;
  int         frame_cnt, frame_cnt_n;
  logic [3:0] power_n;
  coord_t     pull_n, dx, dy, dx_n, dy_n;
  coord_t     vx_n, vy_n;
  logic       hit_n;

  function automatic int pwr(input logic [3:0] p);
    return $signed({28'd0, p});
  endfunction

  // Signed divide truncates toward zero, matching the physics stage.
  function automatic int vel(input int d, input logic [3:0] p);
    int prod;
    prod = d * pwr(p);
    return prod / VEL_DIV;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] p);
    return (p == 4'(MAX_POWER)) ? p : p + 4'd1;
  endfunction

  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    power_n     = power;
    pull_n      = pull_back;
    dx_n        = dx;
    dy_n        = dy;
    vx_n        = velocityX;
    vy_n        = velocityY;
    hit_n       = 1'b0;
    if (start_frame) begin
      unique case (state)
        IDLE: begin
          if (shoot_key && !balls_moving) begin
            state_n     = CHARGE;
            power_n     = 4'd0;
            frame_cnt_n = 0;
            pull_n      = 0;
          end
        end
        CHARGE: begin
          if (shoot_key) begin
            if (frame_cnt == CHARGE_DIV - 1) begin
              frame_cnt_n = 0;
              power_n     = sat_inc(power);
            end else begin
              frame_cnt_n = frame_cnt + 1;
            end
            pull_n = pwr(power_n) * PULL_STEP;
          end else if (power == 4'd0) begin
            state_n     = IDLE;
            frame_cnt_n = 0;
            pull_n      = 0;
          end else begin
            dx_n    = closeEdgeX - farEdgeX;
            dy_n    = closeEdgeY - farEdgeY;
            state_n = STRIKE;
          end
        end
        STRIKE: begin
          if (pull_back <= STRIKE_STEP) begin
            pull_n      = 0;
            vx_n        = vel(dx, power);
            vy_n        = vel(dy, power);
            hit_n       = 1'b1;
            frame_cnt_n = 0;
            state_n     = WAIT;
          end else begin
            pull_n = pull_back - STRIKE_STEP;
          end
        end
        WAIT: begin
          if (frame_cnt >= MIN_WAIT && !balls_moving) begin
            state_n     = IDLE;
            power_n     = 4'd0;
            frame_cnt_n = 0;
          end else if (frame_cnt < MIN_WAIT) begin
            frame_cnt_n = frame_cnt + 1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= IDLE;
      frame_cnt     <= 0;
      power         <= 4'd0;
      pull_back     <= 0;
      dx            <= 0;
      dy            <= 0;
      velocityX     <= 0;
      velocityY     <= 0;
      hit_pulse     <= 1'b0;
      rotate_enable <= 1'b1;
      cue_visible   <= 1'b1;
    end else begin
      state         <= state_n;
      frame_cnt     <= frame_cnt_n;
      power         <= power_n;
      pull_back     <= pull_n;
      dx            <= dx_n;
      dy            <= dy_n;
      velocityX     <= vx_n;
      velocityY     <= vy_n;
      hit_pulse     <= hit_n;
      rotate_enable <= (state_n == IDLE);
      cue_visible   <= (state_n != WAIT);
    end
  end

endmodule

// File: tb/tb_cue_strike.sv
// tb_cue_strike: scenario tasks drive shots; a hit monitor pops
// expected velocities from a scoreboard queue on every hit_pulse.
module tb_cue_strike;
  import cue_pkg::*;

  typedef struct {
    int vx;
    int vy;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       start_frame = 1'b0;
  coord_t     closeEdgeX = 0, closeEdgeY = 0;
  coord_t     farEdgeX = 0, farEdgeY = 0;
  logic       shoot_key = 1'b0;
  logic       balls_moving = 1'b0;
  coord_t     pull_back;
  logic [3:0] power;
  logic       hit_pulse;
  coord_t     velocityX, velocityY;
  logic       rotate_enable, cue_visible;

  int   checks = 0;
  int   errors = 0;
  int   hits = 0;
  logic prev_hit = 1'b0;
  exp_t q[$];

  cue_strike dut (
    .clk(clk), .resetN(resetN), .start_frame(start_frame),
    .closeEdgeX(closeEdgeX), .closeEdgeY(closeEdgeY),
    .farEdgeX(farEdgeX), .farEdgeY(farEdgeY),
    .shoot_key(shoot_key), .balls_moving(balls_moving),
    .pull_back(pull_back), .power(power), .hit_pulse(hit_pulse),
    .velocityX(velocityX), .velocityY(velocityY),
    .rotate_enable(rotate_enable), .cue_visible(cue_visible)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (hit_pulse) begin
      hits = hits + 1;
      checks = checks + 1;
      if (prev_hit) begin
        errors = errors + 1;
        $display("FAIL hit_width: hit_pulse high 2+ clocks, need 1");
      end
      if (q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_hit: vel=(%0d,%0d), none expected",
                 velocityX, velocityY);
      end else begin
        exp_t e;
        e = q.pop_front();
        checks = checks + 1;
        if (velocityX !== e.vx || velocityY !== e.vy) begin
          errors = errors + 1;
          $display("FAIL hit_velocity: got (%0d,%0d) need (%0d,%0d)",
                   velocityX, velocityY, e.vx, e.vy);
        end
      end
    end
    prev_hit = hit_pulse;
  end

  task automatic frame();
    @(negedge clk);
    start_frame = 1'b1;
    @(negedge clk);
    start_frame = 1'b0;
  endtask

  task automatic set_edges(input int cx, input int cy,
                           input int fx, input int fy);
    closeEdgeX = cx;
    closeEdgeY = cy;
    farEdgeX   = fx;
    farEdgeY   = fy;
  endtask

  task automatic test_reset();
    checks = checks + 1;
    if (pull_back !== 0 || power !== 4'd0 || hit_pulse !== 1'b0 ||
        velocityX !== 0 || velocityY !== 0 ||
        rotate_enable !== 1'b1 || cue_visible !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL reset_state: pb=%0d pw=%0d hit=%b v=(%0d,%0d) rot=%b vis=%b, need 0 0 0 (0,0) 1 1",
               pull_back, power, hit_pulse, velocityX, velocityY,
               rotate_enable, cue_visible);
    end
  endtask

  task automatic shot(input int hold, input int cx, input int cy,
                      input int fx, input int fy, input int ep,
                      input int epb, input int nstrike, input int evx,
                      input int evy, input bit scramble, input int mv);
    int h0;
    int n;
    exp_t e;
    set_edges(cx, cy, fx, fy);
    shoot_key = 1'b1;
    frame();
    checks = checks + 1;
    if (rotate_enable !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL charge_rotate: rotate_enable=%b need 0", rotate_enable);
    end
    repeat (hold) frame();
    checks = checks + 1;
    if (power !== ep[3:0] || pull_back !== epb) begin
      errors = errors + 1;
      $display("FAIL charge_power: power=%0d pb=%0d need %0d %0d",
               power, pull_back, ep, epb);
    end
    shoot_key = 1'b0;
    e.vx = evx;
    e.vy = evy;
    q.push_back(e);
    h0 = hits;
    frame();
    if (scramble) set_edges(0, 0, 500, -700);
    repeat (nstrike - 1) frame();
    checks = checks + 1;
    if (hits !== h0) begin
      errors = errors + 1;
      $display("FAIL early_hit: hits=%0d need %0d", hits, h0);
    end
    frame();
    checks = checks + 1;
    if (hits !== h0 + 1 || pull_back !== 0 || cue_visible !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL strike_end: hits=%0d pb=%0d vis=%b need %0d 0 0",
               hits, pull_back, cue_visible, h0 + 1);
    end
    if (mv > 0) begin
      balls_moving = 1'b1;
      repeat (mv) frame();
      checks = checks + 1;
      if (cue_visible !== 1'b0 || velocityX !== evx ||
          velocityY !== evy) begin
        errors = errors + 1;
        $display("FAIL wait_moving: vis=%b v=(%0d,%0d) need 0 (%0d,%0d)",
                 cue_visible, velocityX, velocityY, evx, evy);
      end
      balls_moving = 1'b0;
      frame();
      checks = checks + 1;
      if (rotate_enable !== 1'b1 || cue_visible !== 1'b1) begin
        errors = errors + 1;
        $display("FAIL wait_exit: rot=%b vis=%b need 1 1",
                 rotate_enable, cue_visible);
      end
    end
    n = 0;
    while (rotate_enable !== 1'b1 && n < 20) begin
      frame();
      n = n + 1;
    end
    checks = checks + 1;
    if (rotate_enable !== 1'b1 || power !== 4'd0 || cue_visible !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL back_to_idle: rot=%b pw=%0d vis=%b need 1 0 1",
               rotate_enable, power, cue_visible);
    end
  endtask

  task automatic test_short_press();
    int h0;
    h0 = hits;
    set_edges(288, 240, 192, 240);
    shoot_key = 1'b1;
    repeat (3) frame();
    shoot_key = 1'b0;
    frame();
    repeat (4) frame();
    checks = checks + 1;
    if (rotate_enable !== 1'b1 || power !== 4'd0 || hits !== h0) begin
      errors = errors + 1;
      $display("FAIL short_press: rot=%b pw=%0d hits=%0d need 1 0 %0d",
               rotate_enable, power, hits, h0);
    end
  endtask

  task automatic test_moving_ignore();
    balls_moving = 1'b1;
    shoot_key = 1'b1;
    repeat (3) frame();
    checks = checks + 1;
    if (rotate_enable !== 1'b1 || pull_back !== 0) begin
      errors = errors + 1;
      $display("FAIL moving_ignore: rot=%b pb=%0d need 1 0",
               rotate_enable, pull_back);
    end
    shoot_key = 1'b0;
    balls_moving = 1'b0;
    frame();
  endtask

  task automatic test_reset_mid_strike();
    int h0;
    exp_t e;
    h0 = hits;
    set_edges(288, 240, 192, 240);
    shoot_key = 1'b1;
    frame();
    repeat (40) frame();
    shoot_key = 1'b0;
    e.vx = 120;
    e.vy = 0;
    q.push_back(e);
    frame();
    frame();
    checks = checks + 1;
    if (pull_back !== 14) begin
      errors = errors + 1;
      $display("FAIL strike_step: pb=%0d need 14", pull_back);
    end
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    q.delete();
    test_reset();
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    repeat (6) frame();
    checks = checks + 1;
    if (hits !== h0 || rotate_enable !== 1'b1 || power !== 4'd0) begin
      errors = errors + 1;
      $display("FAIL reset_no_hit: hits=%0d rot=%b pw=%0d need %0d 1 0",
               hits, rotate_enable, power, h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    resetN = 1'b1;
    @(negedge clk);
    test_reset();
    // 180 deg cue, 24 frames held
    shot(24, 288, 240, 192, 240, 6, 12, 2, 72, 0, 1'b0, 0);
    // 90 deg cue, saturate, edges move during strike
    shot(100, 320, 208, 320, 112, 15, 30, 5, 0, 180, 1'b1, 0);
    // truncation toward zero with negative dy
    shot(13, 300, 190, 200, 240, 3, 6, 1, 37, -18, 1'b0, 0);
    test_short_press();
    test_moving_ignore();
    shot(8, 288, 240, 192, 240, 2, 4, 1, 24, 0, 1'b0, 10);
    test_reset_mid_strike();
    checks = checks + 1;
    if (q.size() !== 0) begin
      errors = errors + 1;
      $display("FAIL missing_hits: %0d expected hits never seen", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
